tiny_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the tiny CPU execute stage.
- Owns the program counter and issues reads to the synchronous instruction ROM (fixed 1-cycle read latency).
- Buffers returned words in a small prefetch FIFO and hands them to the execute stage as instruction + PC pairs over a valid/ready handshake.
- Execute stage can redirect the PC (jump/branch), which flushes all prefetched and in-flight words.

---
 rtl/tiny_fetch.sv | 141 ++++++++++++++
 tb/tb_tiny_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tiny_fetch.sv
// tiny_fetch: instruction fetch stage feeding the tiny CPU execute stage.
//
// Owns the program counter, issues reads to a synchronous ROM with a fixed
// 1-cycle read latency, buffers returned words in a DEPTH-entry prefetch FIFO,
// and presents instruction + PC pairs over a valid/ready handshake. A redirect
// from the execute stage flushes all prefetched and in-flight words and
// restarts fetch at redirect_pc.
//
// Ports:
//   CLK          in   system clock, all state on rising edge
//   RST_N        in   asynchronous active-low reset
//   rom_rd       out  ROM read strobe (combinational from state and inputs)
//   rom_addr     out  ROM word address
//   rom_data     in   ROM read data, valid the cycle after rom_rd
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   new fetch address
//   ir_valid     out  instruction available at the FIFO head
//   ir           out  instruction word
//   ir_pc        out  word address of ir
//   ir_ready     in   execute stage accepts ir this cycle
module tiny_fetch #(
    parameter int                 ADDR_W   = 4,
    parameter int                 DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ir_valid,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   L_DEPTH = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_tag;        // address issued last cycle
    logic              r_inflight;   // a ROM word arrives this cycle

    logic [31:0]       r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_pop;
    logic              w_push;
    logic [CW:0]       w_occ;

    // Handshake, response capture and projected FIFO occupancy.
    always_comb begin
        w_pop  = ir_valid & ir_ready;
        w_push = r_inflight & ~redirect;
        // Entries stored plus the word on its way, minus the one leaving now.
        // Never negative: a pop implies r_count >= 1.
        w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    end

    // ROM request: a redirect always issues; otherwise only while space remains
    // for the new word once it returns. ir_ready reaches rom_rd combinationally.
    always_comb begin
        if (redirect) begin
            rom_rd   = 1'b1;
            rom_addr = redirect_pc;
        end else begin
            rom_rd   = (w_occ < L_DEPTH);
            rom_addr = r_pc;
        end
    end

    // Output side: FIFO head, forced to zero while empty.
    always_comb begin
        ir_valid = (r_count != {CW{1'b0}});
        if (ir_valid) begin
            ir    = r_mem_data[r_rd_ptr];
            ir_pc = r_mem_pc[r_rd_ptr];
        end else begin
            ir    = 32'd0;
            ir_pc = {ADDR_W{1'b0}};
        end
    end

    // Program counter, in-flight flag and response tag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc       <= RESET_PC;
            r_tag      <= {ADDR_W{1'b0}};
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rom_rd;
            r_tag      <= rom_addr;
            if (redirect) begin
                r_pc <= redirect_pc + ADDR_W'(1);
            end else if (rom_rd) begin
                r_pc <= r_pc + ADDR_W'(1);
            end else begin
                r_pc <= r_pc;
            end
        end
    end

    // Prefetch FIFO: a redirect discards everything, including this cycle's
    // returning word; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= 32'd0;
                r_mem_pc[i]   <= {ADDR_W{1'b0}};
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (redirect) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= rom_data;
                r_mem_pc[r_wr_ptr]   <= r_tag;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_fetch.sv
module tb_tiny_fetch;

    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int NPC   = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data = 32'd0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = 4'd0;
    logic          ir_valid;
    logic [31:0]   ir;
    logic [AW-1:0] ir_pc;
    logic          ir_ready = 1'b0;

    tiny_fetch #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(4'd0)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM, 1-cycle read latency.
    logic [31:0] rom_mem [NPC];
    always @(posedge CLK) if (rom_rd) rom_data <= rom_mem[rom_addr];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: queue of buffered PCs, one pending ROM response.
    int m_fifo[$];
    bit m_infl;
    int m_tag;
    int m_pc;
    int delivered[$];

    task automatic model_reset();
        m_fifo.delete();
        m_infl = 0;
        m_tag  = 0;
        m_pc   = 0;
    endtask

    logic          s_valid, s_rd;
    logic [31:0]   s_ir;
    logic [AW-1:0] s_pc, s_addr;

    // One clock cycle: drive, sample on negedge, compare with model, advance model.
    task automatic cyc(input bit r, input logic [AW-1:0] rp, input bit rdy);
        bit e_valid, e_rd, pop;
        int e_pc, e_addr;
        logic [31:0] e_ir;
        redirect = r; redirect_pc = rp; ir_ready = rdy;
        @(negedge CLK);
        s_valid = ir_valid; s_ir = ir; s_pc = ir_pc; s_rd = rom_rd; s_addr = rom_addr;
        e_valid = (m_fifo.size() > 0);
        e_pc    = e_valid ? m_fifo[0] : 0;
        e_ir    = e_valid ? rom_mem[e_pc] : 32'd0;
        pop     = e_valid && rdy;
        e_rd    = r || ((m_fifo.size() + int'(m_infl) - int'(pop)) < DEPTH);
        e_addr  = r ? int'(rp) : m_pc;
        chk("m_valid", s_valid, e_valid);
        chk("m_ir",    s_ir,    e_ir);
        chk("m_ir_pc", s_pc,    e_pc);
        chk("m_rom_rd", s_rd,   e_rd);
        if (e_rd) chk("m_rom_addr", s_addr, e_addr);
        if (pop) delivered.push_back(e_pc);
        if (r) m_fifo.delete();
        else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_infl) m_fifo.push_back(m_tag);
        end
        m_infl = e_rd;
        m_tag  = e_addr;
        if (r) m_pc = (int'(rp) + 1) % NPC;
        else if (e_rd) m_pc = (m_pc + 1) % NPC;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        bit          r;
        logic [3:0]  rp;
        bit          rdy;
        bit          e_valid;
        logic [3:0]  e_pc;
        logic [31:0] e_ir;
        bit          e_rd;
        logic [3:0]  e_addr;
    } vec_t;
    vec_t tbl[6];

    task automatic run_table(input string tag);
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].r, tbl[i].rp, tbl[i].rdy);
            chk({tag, "_valid"},    s_valid, tbl[i].e_valid);
            chk({tag, "_ir"},       s_ir,    tbl[i].e_ir);
            chk({tag, "_ir_pc"},    s_pc,    tbl[i].e_pc);
            chk({tag, "_rom_rd"},   s_rd,    tbl[i].e_rd);
            chk({tag, "_rom_addr"}, s_addr,  tbl[i].e_addr);
        end
    endtask

    initial begin
        logic [AW-1:0] held;
        int n;
        bit saw5;
        for (int i = 0; i < NPC; i++) rom_mem[i] = 32'h100 + i;

        // Reset release, ir_ready=1: issue 0 in cycle 0, first valid in cycle 2.
        tbl[0] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,   1'b1, 4'd0};
        tbl[1] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,   1'b1, 4'd1};
        tbl[2] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 32'h100, 1'b1, 4'd2};
        tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 32'h101, 1'b1, 4'd3};
        tbl[4] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 32'h102, 1'b1, 4'd4};
        tbl[5] = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 32'h103, 1'b1, 4'd5};

        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_ir",    ir,       32'd0);
        chk("rst_ir_pc", ir_pc,    4'd0);
        RST_N = 1'b1;
        delivered.delete();
        run_table("start");

        // Continuous stream: 20 instructions with wrap.
        n = 0;
        while (delivered.size() < 20 && n < 60) begin cyc(1'b0, 4'd0, 1'b1); n++; end
        chk("wrap_count", delivered.size() >= 20, 1'b1);
        for (int i = 0; i < 20 && i < delivered.size(); i++) chk("wrap_seq", delivered[i], i % NPC);

        // Stall for 5 cycles: head holds, fetch stops once full.
        cyc(1'b0, 4'd0, 1'b0);
        held = s_pc;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'd0, 1'b0);
            chk("stall_hold_pc", s_pc, held);
            chk("stall_hold_valid", s_valid, 1'b1);
        end
        chk("stall_rd_off", s_rd, 1'b0);
        delivered.delete();
        repeat (6) cyc(1'b0, 4'd0, 1'b1);
        chk("resume_first", delivered[0], held);
        for (int i = 1; i < delivered.size(); i++)
            chk("resume_seq", delivered[i], (delivered[i-1] + 1) % NPC);

        // Redirect to 9 while streaming (coincides with a pop).
        cyc(1'b1, 4'd9, 1'b1);
        delivered.delete();
        cyc(1'b0, 4'd0, 1'b1);
        chk("redir_gap", s_valid, 1'b0);
        cyc(1'b0, 4'd0, 1'b1);
        chk("redir_valid", s_valid, 1'b1);
        chk("redir_ir",    s_ir,    32'h109);
        chk("redir_pc",    s_pc,    4'd9);
        repeat (3) cyc(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < delivered.size(); i++) chk("redir_seq", delivered[i], 9 + i);

        // Back-to-back redirects: last one wins.
        cyc(1'b1, 4'd5, 1'b1);
        cyc(1'b1, 4'd12, 1'b1);
        delivered.delete();
        repeat (6) cyc(1'b0, 4'd0, 1'b1);
        chk("dbl_first", delivered[0], 12);
        saw5 = 1'b0;
        foreach (delivered[i]) if (delivered[i] == 5) saw5 = 1'b1;
        chk("dbl_no_stale", saw5, 1'b0);

        // Reset mid-stream for one cycle.
        ir_ready = 1'b1;
        RST_N = 1'b0;
        #1;
        chk("mrst_valid", ir_valid, 1'b0);
        chk("mrst_ir",    ir,       32'd0);
        chk("mrst_ir_pc", ir_pc,    4'd0);
        model_reset();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        delivered.delete();
        run_table("restart");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) == 0, 4'($urandom_range(0, NPC - 1)), $urandom_range(0, 9) < 7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
